// File: rtl/seq_logic_unit_if.sv
// Handshake and operand/result bundle for seq_logic_unit.
// The controller side uses master and the logic unit uses slave.
interface seq_logic_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ones;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, zero, ones
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, zero, ones
  );
endinterface

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/ANDN) that computes SLICE_W bits
// per cycle, LSB slice first, and produces zero/all-ones flags.
module seq_logic_unit #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_logic_unit_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, res;
  logic [1:0]       opr;
  logic             zero_r, ones_r;
  logic             accept, last;

  logic [SLICE_W-1:0] sa, sb, s_and, s_or, s_xor, s_andn, sf;

  assign sa = opa[cnt*SLICE_W +: SLICE_W];
  assign sb = opb[cnt*SLICE_W +: SLICE_W];

  // Slice-wide cell arrays; the op register only selects among them.
  assign s_and  = sa & sb;
  assign s_or   = sa | sb;
  assign s_xor  = sa ^ sb;
  assign s_andn = sa & ~sb;

  always_comb begin
    sf = s_and;
    unique case (opr)
      2'b00:   sf = s_and;
      2'b01:   sf = s_or;
      2'b10:   sf = s_xor;
      default: sf = s_andn;
    endcase
  end

  assign last = (cnt == CW'(NSLICE - 1));

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = rst_n;
        accept       = bus.in_valid & rst_n;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      default: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      opr    <= '0;
      res    <= '0;
      zero_r <= 1'b0;
      ones_r <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      opa    <= bus.in1;
      opb    <= bus.in2;
      opr    <= bus.op;
      res    <= '0;
      zero_r <= 1'b1;
      ones_r <= 1'b1;
    end else if (state == BUSY) begin
      res[cnt*SLICE_W +: SLICE_W] <= sf;
      zero_r <= zero_r & (sf == '0);
      ones_r <= ones_r & (sf == '1);
      cnt    <= last ? '0 : cnt + 1'b1;
    end
  end

  // Flags keep accumulating through BUSY but are only exposed while DONE.
  assign bus.out  = res;
  assign bus.zero = zero_r & (state == DONE);
  assign bus.ones = ones_r & (state == DONE);
endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit: directed vector table, backpressure,
// mid-operation reset and randomized operations against a reference model.
module tb_seq_logic_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_logic_unit_if #(.WIDTH(16)) bus ();

  seq_logic_unit #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    int          hold;
    logic [15:0] exp_out;
    logic        exp_zero;
    logic        exp_ones;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // Runs one full transaction; checks latency, backpressure and the IDLE return.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input int hold, output logic [15:0] r, output logic z,
                       output logic on);
    int n;
    int lat;
    logic [15:0] r0;
    logic z0, o0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in1 = a;
    bus.in2 = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.in1 = 16'($urandom);
      bus.in2 = 16'($urandom);
      bus.op  = 2'($urandom);
      chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32'd4);
    r0 = bus.out;
    z0 = bus.zero;
    o0 = bus.ones;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      @(negedge clk);
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold_out", {16'd0, bus.out}, {16'd0, r0});
      chk("hold_zero", {31'd0, bus.zero}, {31'd0, z0});
      chk("hold_ones", {31'd0, bus.ones}, {31'd0, o0});
    end
    bus.in_valid = 1'b0;
    r = r0;
    z = z0;
    on = o0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_out_kept", {16'd0, bus.out}, {16'd0, r0});
    chk("idle_zero_clear", {31'd0, bus.zero}, 32'd0);
  endtask

  initial begin
    logic [15:0] r, a, b;
    logic [1:0]  op;
    logic z, on;
    int sel;

    vecs.push_back('{16'hF0F0, 16'hFF00, 2'd0, 0, 16'hF000, 1'b0, 1'b0});
    vecs.push_back('{16'hFF00, 16'h00FF, 2'd1, 0, 16'hFFFF, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h00FF, 2'd1, 1, 16'h12FF, 1'b0, 1'b0});
    vecs.push_back('{16'hAAAA, 16'hAAAA, 2'd2, 0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0F0F, 2'd3, 5, 16'hF0F0, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 2'd0, 0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h5A5A, 16'hFFFF, 2'd3, 2, 16'h0000, 1'b1, 1'b0});

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.op = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out", {16'd0, bus.out}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
    chk("rst_ones", {31'd0, bus.ones}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, r, z, on);
      chk($sformatf("vec%0d_out", i), {16'd0, r}, {16'd0, vecs[i].exp_out});
      chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("vec%0d_ones", i), {31'd0, on}, {31'd0, vecs[i].exp_ones});
    end

    // Reset asserted asynchronously during the second BUSY cycle.
    bus.in1 = 16'h1234;
    bus.in2 = 16'hFFFF;
    bus.op = 2'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_out", {16'd0, bus.out}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_ones", {31'd0, bus.ones}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h00FF, 16'h0FF0, 2'd0, 0, r, z, on);
    chk("after_rst_out", {16'd0, r}, 32'h00F0);
    chk("after_rst_zero", {31'd0, z}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 5));
      a = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      b = (sel == 2) ? a : (sel == 3) ? ~a : 16'($urandom);
      op = 2'($urandom);
      do_op(a, b, op, int'($urandom_range(0, 2)), r, z, on);
      chk($sformatf("rnd%0d_out", i), {16'd0, r}, {16'd0, ref_result(a, b, op)});
      chk($sformatf("rnd%0d_zero", i), {31'd0, z}, {31'd0, ref_result(a, b, op) == 16'h0000});
      chk($sformatf("rnd%0d_ones", i), {31'd0, on}, {31'd0, ref_result(a, b, op) == 16'hFFFF});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
- Multi-cycle 16-bit bitwise logic unit in the execute stage.
- Produces AND/OR/XOR/ANDN results and zero/all-ones flags for the ALU result mux.
- Processes SLICE_W bits per cycle, LSB slice first, using slice-wide and2/or2/xor2 cell arrays.
- Valid/ready handshakes on input and output so the pipeline controller can stall it.

Parameters:
- WIDTH, 16, operand and result width.
- SLICE_W, 4, bits processed per cycle. WIDTH must be a multiple of SLICE_W; NSLICE = WIDTH/SLICE_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  unit can accept operands.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 ANDN (in1 & ~in2).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- ones  output  1  out == all ones.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- rst_n low: state IDLE, slice counter 0, out/zero/ones/out_valid = 0, operand regs = 0, in_ready = 0 (gated combinationally by rst_n).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: capture in1/in2/op into internal regs, clear result reg, counter := 0, go to BUSY.
  - Later changes on in1/in2/op have no effect.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each edge: result[cnt*SLICE_W +: SLICE_W] := f(opA slice, opB slice, op); cnt := cnt+1.
  - On the edge writing slice NSLICE-1: go to DONE, cnt wraps to 0.
- Latency: accept edge E, result complete and out_valid = 1 after edge E+NSLICE (4 cycles at defaults).
- DONE:
  - out_valid = 1. out, zero and ones are registered and stable.
  - On an edge with out_ready = 1: go to IDLE, out_valid := 0. out keeps its last value until the next accept.
  - out_ready low: hold indefinitely; in_ready stays 0. There is no overlap of a new accept with a pending result.
- zero/ones:
  - Accumulated per slice: zero := zero_so_far & (slice == 0); ones likewise.
  - Initialised to 1 at accept; valid only when out_valid = 1 (0 outside DONE after reset).
- out_ready while not in DONE: ignored. in_valid outside IDLE: ignored.
- Reset mid-operation (BUSY or DONE): immediate abort to reset values. The first accept after rst_n rises behaves normally.
- Zero operands are not special: every op runs the full NSLICE cycles.

Test Plan:
- AND: in1=0xF0F0, in2=0xFF00, op=00, out_ready=1 -> out_valid asserts exactly 4 cycles after accept; out=0xF000, zero=0, ones=0; returns to IDLE next edge, in_ready=1.
- OR/ones: in1=0xFF00, in2=0x00FF, op=01 -> out=0xFFFF, ones=1, zero=0. Then in1=0x1234, in2=0x00FF -> out=0x12FF, ones=0.
- XOR/zero and ANDN:
  - in1=in2=0xAAAA, op=10 -> out=0x0000, zero=1.
  - in1=0xFFFF, in2=0x0F0F, op=11 -> out=0xF0F0.
- Backpressure and operand isolation:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, out, zero stable; in_ready=0; in_valid pulses ignored.
  - Change in1/in2 during BUSY -> result reflects the captured values only.
- Reset mid-op: assert rst_n=0 asynchronously on the 2nd BUSY cycle -> out_valid=0, out=0, in_ready=0 immediately; release, issue AND 0x00FF & 0x0FF0 -> out=0x00F0 after 4 cycles.
